// File: rtl/cpu_paddle_driver.sv
// Computer opponent for one paddle: watches the ball on the 1 ms tick and
// drives the paddle's active-low up/down buttons toward a target y.
module cpu_paddle_driver #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned SIDE      = 1,
    parameter int unsigned SAMPLE_MS = 4,
    parameter int unsigned REACT_MS  = 20,
    parameter int unsigned DEADBAND  = 4,
    parameter int unsigned MAX_RUN   = 200,
    parameter int unsigned REST_MS   = 30
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] x_ball,
    input  logic [9:0] y_ball,
    input  logic [9:0] y_paddle,
    output logic       btn_up_n,
    output logic       btn_down_n,
    output logic [2:0] state
);

    localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned SW = (SAMPLE_MS > 1) ? $clog2(SAMPLE_MS) : 1;
    localparam int unsigned RW = (REACT_MS > 1) ? $clog2(REACT_MS) : 1;
    localparam int unsigned UW = $clog2(MAX_RUN + 1);
    localparam int unsigned TW = (REST_MS > 1) ? $clog2(REST_MS) : 1;

    localparam logic [9:0]         CENTER = 10'(V_ACTIVE / 2);
    localparam logic signed [10:0] DB     = 11'(DEADBAND);
    localparam logic signed [10:0] NEG_DB = -DB;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RECENTER = 3'd1;
    localparam logic [2:0] WAIT     = 3'd2;
    localparam logic [2:0] TRACK    = 3'd3;
    localparam logic [2:0] REST     = 3'd4;

    logic [SW-1:0] sample_cnt;
    logic [XW-1:0] x_prev;
    logic          prev_valid;
    logic          approach;
    logic [9:0]    target;
    logic [RW-1:0] react_cnt;
    logic [UW-1:0] run_cnt;
    logic [TW-1:0] rest_cnt;

    logic [2:0]    state_next;
    logic [9:0]    target_next;
    logic [RW-1:0] react_next;
    logic [UW-1:0] run_next;
    logic [TW-1:0] rest_next;
    logic          up_next;
    logic          down_next;

    logic               sample;
    logic [XW-1:0]      x_cur;
    logic               approach_now;
    logic signed [10:0] err;
    logic               want_up;
    logic               want_down;

    assign sample = (sample_cnt == SW'(SAMPLE_MS - 1));
    assign x_cur  = XW'(x_ball);

    // Direction decision; an unchanged x keeps the previous verdict.
    always_comb begin
        approach_now = approach;
        if (sample && prev_valid) begin
            if (x_cur > x_prev) begin
                approach_now = (SIDE != 0);
            end else if (x_cur < x_prev) begin
                approach_now = (SIDE == 0);
            end
        end
    end

    assign err       = $signed({1'b0, target}) - $signed({1'b0, y_paddle});
    assign want_down = (err > DB);
    assign want_up   = (err < NEG_DB);

    always_comb begin
        state_next  = state;
        target_next = target;
        react_next  = react_cnt;
        run_next    = run_cnt;
        rest_next   = rest_cnt;

        if (state == TRACK && sample) begin
            target_next = y_ball;
        end

        case (state)
            IDLE: begin
                state_next  = RECENTER;
                target_next = CENTER;
            end
            RECENTER: begin
                if (sample && prev_valid && approach_now) begin
                    state_next = WAIT;
                    react_next = '0;
                end
            end
            WAIT: begin
                // A receding ball outranks the reaction timeout.
                if (sample && !approach_now) begin
                    state_next  = RECENTER;
                    target_next = CENTER;
                end else if (react_cnt == RW'(REACT_MS - 1)) begin
                    state_next  = TRACK;
                    run_next    = '0;
                    target_next = y_ball;
                end else begin
                    react_next = react_cnt + RW'(1);
                end
            end
            TRACK: begin
                if (sample && !approach_now) begin
                    state_next  = RECENTER;
                    target_next = CENTER;
                end else if (run_cnt == UW'(MAX_RUN)) begin
                    state_next = REST;
                    rest_next  = '0;
                end else if (want_up || want_down) begin
                    run_next = run_cnt + UW'(1);
                end else begin
                    run_next = '0;
                end
            end
            REST: begin
                if (rest_cnt == TW'(REST_MS - 1)) begin
                    if (approach_now) begin
                        state_next  = TRACK;
                        run_next    = '0;
                        target_next = y_ball;
                    end else begin
                        state_next  = RECENTER;
                        target_next = CENTER;
                    end
                end else begin
                    rest_next = rest_cnt + TW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (!enable) begin
            state_next = IDLE;
        end

        // Buttons only move the paddle while staying in a driving state.
        up_next   = 1'b1;
        down_next = 1'b1;
        if (state_next == state && (state == RECENTER || state == TRACK)) begin
            up_next   = !want_up;
            down_next = !want_down;
        end
    end

    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            state      <= IDLE;
            btn_up_n   <= 1'b1;
            btn_down_n <= 1'b1;
            sample_cnt <= '0;
            x_prev     <= '0;
            prev_valid <= 1'b0;
            approach   <= 1'b0;
            target     <= CENTER;
            react_cnt  <= '0;
            run_cnt    <= '0;
            rest_cnt   <= '0;
        end else begin
            state      <= state_next;
            btn_up_n   <= up_next;
            btn_down_n <= down_next;
            sample_cnt <= sample ? '0 : sample_cnt + SW'(1);
            approach   <= approach_now;
            if (sample) begin
                x_prev     <= x_cur;
                prev_valid <= 1'b1;
            end
            target    <= target_next;
            react_cnt <= react_next;
            run_cnt   <= run_next;
            rest_cnt  <= rest_next;
        end
    end

endmodule

// File: tb/tb_cpu_paddle_driver.sv
// Bench for cpu_paddle_driver: directed scenarios plus random segments,
// all checked against a timestamp-based behavioural model.
module tb_cpu_paddle_driver;

    localparam int SAMPLE = 4;
    localparam int REACT  = 20;
    localparam int DBAND  = 4;
    localparam int MAXRUN = 200;
    localparam int RESTL  = 30;
    localparam int VACT   = 480;
    localparam int SIDE_P = 1;

    logic       clk_1ms = 1'b0;
    logic       reset;
    logic       enable;
    logic [9:0] x_ball;
    logic [9:0] y_ball;
    logic [9:0] y_paddle;
    logic       btn_up_n;
    logic       btn_down_n;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    int dx = 0;
    bit paddle_on = 0;

    cpu_paddle_driver dut (
        .clk_1ms   (clk_1ms),
        .reset     (reset),
        .enable    (enable),
        .x_ball    (x_ball),
        .y_ball    (y_ball),
        .y_paddle  (y_paddle),
        .btn_up_n  (btn_up_n),
        .btn_down_n(btn_down_n),
        .state     (state)
    );

    always #5 clk_1ms = ~clk_1ms;

    // Model: sample instants from a tick count, state ages from entry timestamps.
    int m_state, m_up, m_dn, m_xprev, m_pvalid, m_appr, m_target;
    int m_ticks, m_enter, m_run;

    always @(posedge clk_1ms) begin : model_b
        int smp, an, age, err, wu, wd, nxt;
        if (!reset) begin
            m_state = 0; m_up = 1; m_dn = 1;
            m_xprev = 0; m_pvalid = 0; m_appr = 0; m_target = VACT / 2;
            m_ticks = 0; m_enter = 0; m_run = 0;
        end else begin
            smp = (m_ticks % SAMPLE) == (SAMPLE - 1);
            an  = m_appr;
            if (smp && m_pvalid && int'(x_ball) != m_xprev)
                an = SIDE_P ? (int'(x_ball) > m_xprev) : (int'(x_ball) < m_xprev);
            age = m_ticks - m_enter;
            err = m_target - int'(y_paddle);
            wd  = err > DBAND;
            wu  = err < -DBAND;
            nxt = m_state;
            case (m_state)
                0: nxt = 1;
                1: if (smp && m_pvalid && an) nxt = 2;
                2: if (smp && !an) nxt = 1; else if (age == REACT - 1) nxt = 3;
                3: if (smp && !an) nxt = 1; else if (m_run == MAXRUN) nxt = 4;
                4: if (age == RESTL - 1) nxt = an ? 3 : 1;
                default: nxt = 0;
            endcase
            if (!enable) nxt = 0;
            if (nxt == m_state && (m_state == 1 || m_state == 3)) begin
                m_up = !wu; m_dn = !wd;
            end else begin
                m_up = 1; m_dn = 1;
            end
            if (nxt == 3 && m_state != 3) m_run = 0;
            else if (m_state == 3) m_run = (wu || wd) ? ((m_run < MAXRUN) ? m_run + 1 : MAXRUN) : 0;
            if (m_state == 3 && smp) m_target = int'(y_ball);
            if (nxt == 1 && m_state != 1) m_target = VACT / 2;
            if (nxt == 3 && m_state != 3) m_target = int'(y_ball);
            if (smp) begin
                if (m_pvalid) m_appr = an;
                m_xprev = int'(x_ball);
                m_pvalid = 1;
            end
            if (nxt != m_state) m_enter = m_ticks + 1;
            m_state = nxt;
            m_ticks++;
        end
    end

    // One game tick; the ball and (optionally) the paddle move after the edge.
    task automatic tick();
        @(posedge clk_1ms);
        #1;
        if (paddle_on) begin
            if (!btn_down_n && y_paddle < 10'd1023) y_paddle = y_paddle + 10'd1;
            if (!btn_up_n && y_paddle > 10'd0) y_paddle = y_paddle - 10'd1;
        end
        x_ball = 10'(int'(x_ball) + dx);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic go_track(input logic [9:0] yb, input logic [9:0] yp, output bit ok);
        enable = 1'b1; x_ball = 10'd0; dx = 1; y_ball = yb; y_paddle = yp; paddle_on = 0;
        do_reset();
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (state == 3'd3) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; x_ball = 10'd50; dx = 1; y_ball = 10'd10; y_paddle = 10'd400;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if ({state, btn_up_n, btn_down_n} !== {3'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_hold: got st=%0d up=%b dn=%b want st=0 up=1 dn=1", state, btn_up_n, btn_down_n);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (state !== 3'd1) begin
            n_bad++;
            $display("FAIL reset_release: got st=%0d want st=1", state);
        end
    endtask

    task automatic test_recenter();
        logic [9:0] yp [4];
        logic [1:0] ex [4];
        yp = '{10'd244, 10'd245, 10'd236, 10'd235};
        ex = '{2'b11, 2'b01, 2'b11, 2'b10};
        enable = 1'b1; x_ball = 10'd500; dx = -1; y_ball = 10'($urandom_range(479, 0));
        y_paddle = 10'd300; paddle_on = 0;
        do_reset();
        tick();
        n_cmp++;
        if (state !== 3'd1) begin
            n_bad++;
            $display("FAIL recenter_enter: got st=%0d want st=1", state);
        end
        tick();
        n_cmp++;
        if ({btn_up_n, btn_down_n} !== 2'b01) begin
            n_bad++;
            $display("FAIL recenter_up: got up=%b dn=%b want up=0 dn=1", btn_up_n, btn_down_n);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if ({state, btn_up_n, btn_down_n} !== {3'(m_state), 1'(m_up), 1'(m_dn)} || state !== 3'd1) begin
                n_bad++;
                $display("FAIL recenter_hold: got st=%0d up=%b dn=%b want st=1 model up=%0d dn=%0d",
                         state, btn_up_n, btn_down_n, m_up, m_dn);
            end
        end
        for (int i = 0; i < 4; i++) begin
            y_paddle = yp[i];
            tick();
            n_cmp++;
            if ({btn_up_n, btn_down_n} !== ex[i]) begin
                n_bad++;
                $display("FAIL recenter_deadband y=%0d: got up=%b dn=%b want %b", yp[i], btn_up_n, btn_down_n, ex[i]);
            end
        end
    endtask

    task automatic test_track();
        int n;
        int w;
        bit hi;
        enable = 1'b1; x_ball = 10'd100; dx = 1; y_ball = 10'd100; y_paddle = 10'd240; paddle_on = 1;
        do_reset();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (state == 3'd2) break;
        end
        n_cmp++;
        if (state !== 3'd2 || n != 2 * SAMPLE) begin
            n_bad++;
            $display("FAIL track_wait_entry: got st=%0d after %0d ticks want st=2 after %0d", state, n, 2 * SAMPLE);
        end
        w = 0; hi = 1;
        while (state == 3'd2 && w < 40) begin
            if ({btn_up_n, btn_down_n} !== 2'b11) hi = 0;
            tick();
            w++;
        end
        n_cmp++;
        if (w != REACT || state !== 3'd3 || !hi || {btn_up_n, btn_down_n} !== 2'b11) begin
            n_bad++;
            $display("FAIL track_react: got %0d wait ticks st=%0d buttons_high=%0d want %0d ticks st=3 buttons_high=1",
                     w, state, hi, REACT);
        end
        tick();
        n_cmp++;
        if ({btn_up_n, btn_down_n} !== 2'b01) begin
            n_bad++;
            $display("FAIL track_first_up: got up=%b dn=%b want up=0 dn=1", btn_up_n, btn_down_n);
        end
        for (int i = 0; i < 300; i++) begin
            if ({btn_up_n, btn_down_n} === 2'b11) break;
            tick();
            n_cmp++;
            if ({state, btn_up_n, btn_down_n} !== {3'(m_state), 1'(m_up), 1'(m_dn)}) begin
                n_bad++;
                $display("FAIL track_model: got st=%0d up=%b dn=%b want st=%0d up=%0d dn=%0d",
                         state, btn_up_n, btn_down_n, m_state, m_up, m_dn);
            end
        end
        n_cmp++;
        if ({btn_up_n, btn_down_n} !== 2'b11 || y_paddle !== 10'd104 || state !== 3'd3) begin
            n_bad++;
            $display("FAIL track_release: got up=%b dn=%b y=%0d st=%0d want up=1 dn=1 y=104 st=3",
                     btn_up_n, btn_down_n, y_paddle, state);
        end
    endtask

    task automatic test_run_limit();
        bit ok;
        int lo;
        int r;
        bit hi;
        go_track(10'd40, 10'd440, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL run_reach_track: got st=%0d want st=3", state);
        end
        tick();
        lo = 0;
        while (btn_up_n === 1'b0 && lo < 300) begin
            lo++;
            tick();
        end
        n_cmp++;
        if (lo != MAXRUN || state !== 3'd4 || {btn_up_n, btn_down_n} !== 2'b11) begin
            n_bad++;
            $display("FAIL run_limit: got %0d low ticks then st=%0d up=%b dn=%b want %0d then st=4 up=1 dn=1",
                     lo, state, btn_up_n, btn_down_n, MAXRUN);
        end
        r = 0; hi = 1;
        while (state == 3'd4 && r < 100) begin
            if ({btn_up_n, btn_down_n} !== 2'b11) hi = 0;
            tick();
            r++;
        end
        n_cmp++;
        if (r != RESTL || state !== 3'd3 || !hi) begin
            n_bad++;
            $display("FAIL run_rest: got %0d rest ticks st=%0d buttons_high=%0d want %0d st=3 buttons_high=1",
                     r, state, hi, RESTL);
        end
        tick();
        n_cmp++;
        if ({state, btn_up_n, btn_down_n} !== {3'd3, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL run_resume: got st=%0d up=%b dn=%b want st=3 up=0 dn=1", state, btn_up_n, btn_down_n);
        end
    endtask

    task automatic test_recede_wait();
        int n;
        bit saw_track;
        enable = 1'b1; x_ball = 10'd300; dx = 1; y_ball = 10'($urandom_range(479, 0));
        y_paddle = 10'd240; paddle_on = 1;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (state == 3'd2) break;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({state, btn_up_n, btn_down_n} !== {3'(m_state), 1'(m_up), 1'(m_dn)} || state !== 3'd2) begin
                n_bad++;
                $display("FAIL recede_wait_hold: got st=%0d up=%b dn=%b want st=2 model st=%0d",
                         state, btn_up_n, btn_down_n, m_state);
            end
        end
        x_ball = x_ball - 10'd8;
        dx = -1;
        n = 0; saw_track = 0;
        while (state == 3'd2 && n < 2 * SAMPLE) begin
            tick();
            n++;
            if (state == 3'd3) saw_track = 1;
        end
        n_cmp++;
        if (state !== 3'd1 || n > SAMPLE || saw_track) begin
            n_bad++;
            $display("FAIL recede_wait: got st=%0d after %0d ticks track_seen=%0d want st=1 within %0d ticks track_seen=0",
                     state, n, saw_track, SAMPLE);
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        go_track(10'd40, 10'd440, ok);
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (!ok || {state, btn_up_n, btn_down_n} !== {3'd3, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL enable_pre: got st=%0d up=%b dn=%b want st=3 up=0 dn=1", state, btn_up_n, btn_down_n);
        end
        enable = 1'b0;
        tick();
        n_cmp++;
        if ({state, btn_up_n, btn_down_n} !== {3'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL enable_drop: got st=%0d up=%b dn=%b want st=0 up=1 dn=1", state, btn_up_n, btn_down_n);
        end
        enable = 1'b1;
        tick();
        n_cmp++;
        if (state !== 3'd1) begin
            n_bad++;
            $display("FAIL enable_restore: got st=%0d want st=1", state);
        end
    endtask

    task automatic test_reset_mid_track();
        bit ok;
        int n;
        go_track(10'd40, 10'd440, ok);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if (!ok || {state, btn_up_n, btn_down_n} !== {3'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_mid_track: got st=%0d up=%b dn=%b want st=0 up=1 dn=1", state, btn_up_n, btn_down_n);
        end
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (state == 3'd2) break;
        end
        n_cmp++;
        if (state !== 3'd2 || n != 2 * SAMPLE) begin
            n_bad++;
            $display("FAIL reset_mid_resample: got st=%0d after %0d ticks want st=2 after %0d", state, n, 2 * SAMPLE);
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            len = int'($urandom_range(80, 10));
            dx = int'($urandom_range(6, 0)) - 3;
            enable = ($urandom_range(7, 0) != 0);
            y_ball = 10'($urandom_range(479, 0));
            paddle_on = 1'($urandom_range(1, 0));
            if (!paddle_on) y_paddle = 10'($urandom_range(479, 0));
            reset = ($urandom_range(14, 0) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < len; i++) begin
                tick();
                if (i == 0) reset = 1'b1;
                n_cmp++;
                if ({state, btn_up_n, btn_down_n} !== {3'(m_state), 1'(m_up), 1'(m_dn)}) begin
                    n_bad++;
                    $display("FAIL random seg=%0d i=%0d: got st=%0d up=%b dn=%b want st=%0d up=%0d dn=%0d",
                             seg, i, state, btn_up_n, btn_down_n, m_state, m_up, m_dn);
                end
                if ($urandom_range(30, 0) == 0) y_ball = 10'($urandom_range(479, 0));
            end
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; x_ball = '0; y_ball = '0; y_paddle = 10'd240;
        test_reset();
        test_recenter();
        test_track();
        test_run_limit();
        test_recede_wait();
        test_enable_drop();
        test_reset_mid_track();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
